// File: rtl/seq_alu_pkg.sv
// Shared types for seq_alu: opcode and FSM state enums plus opcode class helpers.
// Optional macro SEQ_ALU_MULDIV_EN enables the iterative multiply/divide unit.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_BEQ  = 4'd7,
    ALU_BNE  = 4'd8,
    ALU_BLT  = 4'd9,
    ALU_BGE  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_BLTU = 4'd12,
    ALU_MUL  = 4'd13,
    ALU_DIVU = 4'd14,
    ALU_REMU = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } alu_state_e;

  function automatic logic is_compare(alu_op_e op);
    return (op inside {ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU});
  endfunction

  function automatic logic is_multicycle(alu_op_e op);
    return (op inside {ALU_MUL, ALU_DIVU, ALU_REMU});
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response channel of seq_alu.
//   master: drives in_valid, in_1, in_2, control, out_ready
//   slave : drives in_ready, out_valid, result, bcond
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_1;
  logic [WIDTH-1:0] in_2;
  logic [3:0]       control;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             bcond;

  modport master (
    output in_valid, in_1, in_2, control, out_ready,
    input  in_ready, out_valid, result, bcond
  );

  modport slave (
    input  in_valid, in_1, in_2, control, out_ready,
    output in_ready, out_valid, result, bcond
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Iterative unit for MUL (low WIDTH bits, shift-add) and DIVU/REMU (restoring division).
// Built only when SEQ_ALU_MULDIV_EN is defined.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   start_i      : load operands and begin (one cycle pulse)
//   op_i         : ALU_MUL, ALU_DIVU or ALU_REMU
//   a_i, b_i     : operands (multiplier/multiplicand, dividend/divisor)
//   done_o       : final step happens on this cycle's edge
//   value_o      : result of the final step, valid while done_o
`ifdef SEQ_ALU_MULDIV_EN
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] value_o
);
  localparam int unsigned CW = $clog2(WIDTH);

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic             is_mul_q, is_rem_q;
  // acc: product accumulator / partial remainder
  // opa: multiplier shifting right / dividend shifting out while quotient shifts in
  // opb: multiplicand shifting left / divisor
  logic [WIDTH-1:0] acc_q, opa_q, opb_q;
  logic [WIDTH-1:0] acc_d, opa_d, opb_d;
  logic [WIDTH:0]   rem_shift, diff;

  always_comb begin
    rem_shift = {acc_q, opa_q[WIDTH-1]};
    diff      = rem_shift - {1'b0, opb_q};
    acc_d     = acc_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    if (is_mul_q) begin
      acc_d = opa_q[0] ? acc_q + opb_q : acc_q;
      opa_d = opa_q >> 1;
      opb_d = opb_q << 1;
    end else if (!diff[WIDTH]) begin
      // No borrow: subtract succeeds. A zero divisor always lands here, giving an
      // all-ones quotient and the dividend as remainder.
      acc_d = diff[WIDTH-1:0];
      opa_d = {opa_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = rem_shift[WIDTH-1:0];
      opa_d = {opa_q[WIDTH-2:0], 1'b0};
    end
  end

  assign done_o  = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign value_o = (is_mul_q || is_rem_q) ? acc_d : opa_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      is_rem_q <= 1'b0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
    end else if (start_i) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      is_mul_q <= (op_i == ALU_MUL);
      is_rem_q <= (op_i == ALU_REMU);
      acc_q    <= '0;
      opa_q    <= a_i;
      opb_q    <= b_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      opa_q <= opa_d;
      opb_q <= opb_d;
      cnt_q <= cnt_q + CW'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/seq_alu.sv
// Handshaked ALU: one operation in flight, result returned over a valid/ready channel.
// Single-cycle ops are evaluated combinationally at acceptance and registered.
// Macro SEQ_ALU_MULDIV_EN: when defined, MUL/DIVU/REMU run on the iterative unit
// (WIDTH steps); when undefined they complete in one cycle with result 0, bcond 0.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : seq_alu_if slave (in_valid/in_ready/in_1/in_2/control,
//             out_valid/out_ready/result/bcond)
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic   clk,
  input logic   reset_n,
  seq_alu_if.slave bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             bcond_q, bcond_d;

  alu_op_e                 op;
  logic [SHW-1:0]          shamt;
  logic signed [WIDTH-1:0] in_1_s, in_2_s;
  logic [WIDTH-1:0]        alu_result;
  logic                    cmp, alu_bcond;

  assign op     = alu_op_e'(bus.control);
  assign shamt  = bus.in_2[SHW-1:0];
  assign in_1_s = $signed(bus.in_1);
  assign in_2_s = $signed(bus.in_2);

  always_comb begin
    alu_result = '0;
    cmp        = 1'b0;
    unique case (op)
      ALU_ADD:  alu_result = bus.in_1 + bus.in_2;
      ALU_SUB:  alu_result = bus.in_1 - bus.in_2;
      ALU_AND:  alu_result = bus.in_1 & bus.in_2;
      ALU_OR:   alu_result = bus.in_1 | bus.in_2;
      ALU_XOR:  alu_result = bus.in_1 ^ bus.in_2;
      ALU_SLL:  alu_result = bus.in_1 << shamt;
      ALU_SRL:  alu_result = bus.in_1 >> shamt;
      ALU_SRA:  alu_result = $unsigned(in_1_s >>> shamt);
      ALU_BEQ:  cmp = (bus.in_1 == bus.in_2);
      ALU_BNE:  cmp = (bus.in_1 != bus.in_2);
      ALU_BLT:  cmp = (in_1_s < in_2_s);
      ALU_BGE:  cmp = (in_1_s >= in_2_s);
      ALU_BLTU: cmp = (bus.in_1 < bus.in_2);
      ALU_MUL, ALU_DIVU, ALU_REMU: ;
    endcase
    alu_bcond = is_compare(op) & cmp;
  end

`ifdef SEQ_ALU_MULDIV_EN
  logic             md_start;
  logic             md_done;
  logic [WIDTH-1:0] md_value;

  seq_alu_muldiv #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .start_i (md_start),
    .op_i    (op),
    .a_i     (bus.in_1),
    .b_i     (bus.in_2),
    .done_o  (md_done),
    .value_o (md_value)
  );
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    bcond_d  = bcond_q;
`ifdef SEQ_ALU_MULDIV_EN
    md_start = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d  = StDone;
          result_d = alu_result;
          bcond_d  = alu_bcond;
`ifdef SEQ_ALU_MULDIV_EN
          if (is_multicycle(op)) begin
            state_d  = StBusy;
            md_start = 1'b1;
            result_d = result_q;
            bcond_d  = bcond_q;
          end
`endif
        end
      end
      StBusy: begin
`ifdef SEQ_ALU_MULDIV_EN
        if (md_done) begin
          state_d  = StDone;
          result_d = md_value;
          bcond_d  = 1'b0;
        end
`else
        state_d = StIdle;
`endif
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      bcond_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      bcond_q  <= bcond_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.result    = result_q;
  assign bus.bcond     = bcond_q;

endmodule
